// File: rtl/dac_spi_streamer_if.sv
// SPI bus from the sample streamer (master) to the external 16-bit DAC (slave).
// Mode 0: sclk idles low, data is presented on the falling edge and sampled on the rising edge.
interface dac_spi_streamer_if;
    logic sclk;
    logic mosi;
    logic cs_n;

    modport master (output sclk, output mosi, output cs_n);
    modport slave  (input  sclk, input  mosi, input  cs_n);
endinterface

// File: rtl/dac_spi_streamer.sv
// Decimates the signed carrier sample stream to a fixed DAC update rate.
// Each update is saturated, offset-binary coded and shifted out as one {command, code} SPI frame.
module dac_spi_streamer #(
    parameter int                  SAMPLE_WIDTH  = 17,
    parameter int                  DAC_WIDTH     = 16,
    parameter int                  CMD_BITS      = 8,
    parameter logic [CMD_BITS-1:0] CMD_WORD      = 8'h30,
    parameter int                  CLK_DIV       = 2,
    parameter int                  SAMPLE_PERIOD = 128,
    parameter bit                  OFFSET_BINARY = 1'b1
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_enable,
    input  logic signed [SAMPLE_WIDTH-1:0] i_sample,
    dac_spi_streamer_if.master             spi,
    output logic                           o_busy,
    output logic                           o_sample_strobe,
    output logic [15:0]                    o_overrun_count
);

    localparam int FRAME_BITS = CMD_BITS + DAC_WIDTH;
    localparam int TICK_W     = $clog2(SAMPLE_PERIOD);
    localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int EXT_W      = SAMPLE_WIDTH - DAC_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    state_t                  state;
    logic [TICK_W-1:0]       tick_cnt;
    logic                    tick;
    logic [DIV_W-1:0]        div_cnt;
    logic                    div_done;
    logic [BIT_W-1:0]        bit_cnt;
    logic                    last_bit;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic [EXT_W-1:0]        ext_bits;
    logic [DAC_WIDTH-1:0]    sat_code;
    logic [DAC_WIDTH-1:0]    dac_code;
    logic                    capture;
    logic                    advance;

    // ------------------------------------------------------------------
    // Sample-rate tick: held at zero while disabled so the first tick
    // lands a full period after enable rises.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset || !i_enable) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_W'(SAMPLE_PERIOD - 1)) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    assign tick = i_enable && (tick_cnt == TICK_W'(SAMPLE_PERIOD - 1));

    // ------------------------------------------------------------------
    // Conversion: in range when the bits above the DAC sign bit are a
    // pure sign extension; otherwise clamp to the nearest full-scale code.
    // ------------------------------------------------------------------
    assign ext_bits = i_sample[SAMPLE_WIDTH-1:DAC_WIDTH-1];

    // NOTE: every branch of this block assigns both outputs up front, so no latch is inferred.
    always_comb begin
        sat_code = i_sample[DAC_WIDTH-1:0];
        if (ext_bits != '0 && ext_bits != '1) begin
            sat_code = i_sample[SAMPLE_WIDTH-1] ? {1'b1, {(DAC_WIDTH-1){1'b0}}}
                                                : {1'b0, {(DAC_WIDTH-1){1'b1}}};
        end
        dac_code = sat_code;
        if (OFFSET_BINARY) begin
            dac_code[DAC_WIDTH-1] = ~sat_code[DAC_WIDTH-1];
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencing
    // ------------------------------------------------------------------
    assign div_done = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign last_bit = (bit_cnt == BIT_W'(FRAME_BITS - 1));
    assign capture  = (state == IDLE) && tick;
    assign advance  = (state == SHIFT) && div_done && spi.sclk && !last_bit;

    // NOTE: the frame shift register is pure datapath; it is always loaded before use, so it has no reset.
    always_ff @(posedge i_clk) begin
        if (capture) begin
            shift_reg <= {CMD_WORD, dac_code};
        end else if (advance) begin
            shift_reg <= shift_reg << 1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state           <= IDLE;
            div_cnt         <= '0;
            bit_cnt         <= '0;
            spi.sclk        <= 1'b0;
            spi.mosi        <= 1'b0;
            spi.cs_n        <= 1'b1;
            o_busy          <= 1'b0;
            o_sample_strobe <= 1'b0;
            o_overrun_count <= '0;
        end else begin
            o_sample_strobe <= 1'b0;

            // A tick is dropped whenever a frame owns the bus, including its last HOLD cycle.
            if (tick && state != IDLE && o_overrun_count != 16'hFFFF) begin
                o_overrun_count <= o_overrun_count + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (tick) begin
                        state           <= SETUP;
                        div_cnt         <= '0;
                        bit_cnt         <= '0;
                        spi.cs_n        <= 1'b0;
                        spi.mosi        <= CMD_WORD[CMD_BITS-1];
                        o_busy          <= 1'b1;
                        o_sample_strobe <= 1'b1;
                    end
                end

                SETUP: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        state   <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                SHIFT: begin
                    if (!div_done) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt <= '0;
                        if (!spi.sclk) begin
                            spi.sclk <= 1'b1;
                        end else begin
                            spi.sclk <= 1'b0;
                            if (last_bit) begin
                                state <= HOLD;
                            end else begin
                                bit_cnt  <= bit_cnt + BIT_W'(1);
                                spi.mosi <= shift_reg[FRAME_BITS-2];
                            end
                        end
                    end
                end

                HOLD: begin
                    if (div_done) begin
                        div_cnt  <= '0;
                        state    <= IDLE;
                        spi.cs_n <= 1'b1;
                        spi.mosi <= 1'b0;
                        o_busy   <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_streamer.sv
// Directed bench for dac_spi_streamer: a bus monitor reconstructs each SPI frame,
// table vectors cover the conversion, and short sequences cover the timing corner cases.
module tb_dac_spi_streamer;

    logic               clk;
    logic               rst;
    logic               en;
    logic               en64;
    logic               enb;
    logic signed [16:0] sample;

    logic        busy, strobe;
    logic [15:0] ovr;
    logic        busy64, strobe64, busy100, strobe100, busy101, strobe101;
    logic [15:0] ovr64, ovr100, ovr101;

    dac_spi_streamer_if spi();
    dac_spi_streamer_if spi64();
    dac_spi_streamer_if spi100();
    dac_spi_streamer_if spi101();

    dac_spi_streamer dut (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_sample(sample), .spi(spi),
        .o_busy(busy), .o_sample_strobe(strobe), .o_overrun_count(ovr)
    );

    dac_spi_streamer #(.SAMPLE_PERIOD(64)) dut64 (
        .i_clk(clk), .i_reset(rst), .i_enable(en64), .i_sample(sample), .spi(spi64),
        .o_busy(busy64), .o_sample_strobe(strobe64), .o_overrun_count(ovr64)
    );

    dac_spi_streamer #(.SAMPLE_PERIOD(100)) dut100 (
        .i_clk(clk), .i_reset(rst), .i_enable(enb), .i_sample(sample), .spi(spi100),
        .o_busy(busy100), .o_sample_strobe(strobe100), .o_overrun_count(ovr100)
    );

    dac_spi_streamer #(.SAMPLE_PERIOD(101)) dut101 (
        .i_clk(clk), .i_reset(rst), .i_enable(enb), .i_sample(sample), .spi(spi101),
        .o_busy(busy101), .o_sample_strobe(strobe101), .o_overrun_count(ovr101)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    // ------------------------------------------------------------------
    // Monitor for the default instance, sampled on the falling clock edge.
    // ------------------------------------------------------------------
    logic [23:0] cur_bits, last_bits;
    int          cur_edges = 0, last_edges = 0, cur_len = 0, last_len = 0;
    int          mon_falls = 0, mon_frames = 0, strobes = 0, glitches = 0, fall_cyc = 0;
    logic        p_cs = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0;

    always @(negedge clk) begin
        if (spi.cs_n === 1'b0) begin
            if (p_cs) begin
                cur_bits  = '0;
                cur_edges = 0;
                cur_len   = 0;
                fall_cyc  = cyc;
                mon_falls++;
            end else if (spi.mosi !== p_mosi && !(p_sclk && !spi.sclk)) begin
                glitches++;
            end
            cur_len++;
            if (spi.sclk && !p_sclk) begin
                cur_bits = {cur_bits[22:0], spi.mosi};
                cur_edges++;
            end
        end else if (!p_cs) begin
            last_bits  = cur_bits;
            last_edges = cur_edges;
            last_len   = cur_len;
            mon_frames++;
        end
        if (strobe === 1'b1) strobes++;
        p_cs   = (spi.cs_n !== 1'b0);
        p_sclk = (spi.sclk === 1'b1);
        p_mosi = spi.mosi;
    end

    // Lighter monitors for the overrun instances.
    int   f64_falls = 0, f64_good = 0, e64 = 0, l64 = 0, f100_falls = 0, f101_falls = 0;
    logic p64_cs = 1'b1, p64_sclk = 1'b0, p100_cs = 1'b1, p101_cs = 1'b1;

    always @(negedge clk) begin
        if (spi64.cs_n === 1'b0) begin
            if (p64_cs) begin
                f64_falls++;
                e64 = 0;
                l64 = 0;
            end
            l64++;
            if (spi64.sclk && !p64_sclk) e64++;
        end else if (!p64_cs && e64 == 24 && l64 == 100) begin
            f64_good++;
        end
        if (spi100.cs_n === 1'b0 && p100_cs) f100_falls++;
        if (spi101.cs_n === 1'b0 && p101_cs) f101_falls++;
        p64_cs   = (spi64.cs_n !== 1'b0);
        p64_sclk = (spi64.sclk === 1'b1);
        p100_cs  = (spi100.cs_n !== 1'b0);
        p101_cs  = (spi101.cs_n !== 1'b0);
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic timeout(input string what);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting", what);
    endtask

    task automatic wait_frame(input int base, input int budget, input string what);
        int n = 0;
        while (mon_frames == base && n < budget) begin
            step(1);
            n++;
        end
        if (mon_frames == base) timeout(what);
    endtask

    task automatic wait_fall(input int base, input int budget, input string what);
        int n = 0;
        while (mon_falls == base && n < budget) begin
            step(1);
            n++;
        end
        if (mon_falls == base) timeout(what);
    endtask

    task automatic wait_edges(input int target, input int budget, input string what);
        int n = 0;
        while (cur_edges < target && n < budget) begin
            step(1);
            n++;
        end
        if (cur_edges < target) timeout(what);
    endtask

    task automatic do_reset();
        // NOTE: stimulus is driven with blocking assignments just after the falling edge, clear of the active edge.
        rst = 1'b1;
        en  = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    typedef struct {
        logic signed [16:0] smp;
        logic [23:0]        frame;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          base, fbase, en_cyc, first_fall, sbase;
        vec_t        v;

        vecs[0] = '{ 17'sd1000,   24'h3083E8 };
        vecs[1] = '{ 17'sd40000,  24'h30FFFF };
        vecs[2] = '{-17'sd40000,  24'h300000 };
        vecs[3] = '{-17'sd1,      24'h307FFF };
        vecs[4] = '{ 17'sd0,      24'h308000 };
        vecs[5] = '{ 17'sd32767,  24'h30FFFF };
        vecs[6] = '{-17'sd32768,  24'h300000 };
        vecs[7] = '{ 17'sd32768,  24'h30FFFF };
        vecs[8] = '{-17'sd32769,  24'h300000 };
        vecs[9] = '{-17'sd1000,   24'h307C18 };

        rst    = 1'b1;
        en     = 1'b0;
        en64   = 1'b0;
        enb    = 1'b0;
        sample = '0;
        step(3);
        rst = 1'b0;

        // Reset state, then idle with enable low.
        step(1);
        check("reset cs_n",     32'(spi.cs_n), 32'd1);
        check("reset sclk",     32'(spi.sclk), 32'd0);
        check("reset mosi",     32'(spi.mosi), 32'd0);
        check("reset busy",     32'(busy),     32'd0);
        check("reset strobe",   32'(strobe),   32'd0);
        check("reset overrun",  32'(ovr),      32'd0);
        step(10);
        check("idle no cs activity", 32'(mon_falls), 32'd0);
        check("idle tick_cnt",       32'(dut.tick_cnt), 32'd0);

        // Conversion table: one frame per vector.
        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
            do_reset();
            sample = v.smp;
            en     = 1'b1;
            en_cyc = cyc;
            base   = mon_frames;
            sbase  = strobes;
            wait_frame(base, 400, $sformatf("vec%0d frame", i));
            check($sformatf("vec%0d bits", i),      32'(last_bits),     32'(v.frame));
            check($sformatf("vec%0d edges", i),     32'(last_edges),    32'd24);
            check($sformatf("vec%0d cs_len", i),    32'(last_len),      32'd100);
            check($sformatf("vec%0d strobes", i),   32'(strobes-sbase), 32'd1);
            check($sformatf("vec%0d start", i),     32'(fall_cyc-en_cyc), 32'd128);
            if (i == 0) begin
                first_fall = fall_cyc;
                wait_frame(base + 1, 400, "vec0 second frame");
                check("frame spacing",  32'(fall_cyc - first_fall), 32'd128);
                check("second bits",    32'(last_bits), 32'h3083E8);
                check("no overrun",     32'(ovr), 32'd0);
            end
        end

        // Enable dropped mid-frame at the 10th rising SCLK edge.
        do_reset();
        sample = 17'sd1000;
        en     = 1'b1;
        base   = mon_frames;
        fbase  = mon_falls;
        wait_fall(fbase, 400, "endrop start");
        wait_edges(10, 200, "endrop edge 10");
        en = 1'b0;
        check("endrop busy mid-frame", 32'(busy), 32'd1);
        wait_frame(base, 200, "endrop frame");
        check("endrop bits",  32'(last_bits),  32'h3083E8);
        check("endrop edges", 32'(last_edges), 32'd24);
        fbase = mon_falls;
        step(300);
        check("endrop no new frame", 32'(mon_falls - fbase), 32'd0);
        check("endrop tick_cnt",     32'(dut.tick_cnt),      32'd0);
        check("endrop cs_n",         32'(spi.cs_n),          32'd1);

        // Reset asserted mid-frame at the 12th rising SCLK edge.
        do_reset();
        sample = -17'sd1;
        en     = 1'b1;
        fbase  = mon_falls;
        wait_fall(fbase, 400, "rst-abort start");
        wait_edges(12, 200, "rst-abort edge 12");
        rst = 1'b1;
        en  = 1'b0;
        step(1);
        check("abort cs_n", 32'(spi.cs_n), 32'd1);
        check("abort sclk", 32'(spi.sclk), 32'd0);
        check("abort busy", 32'(busy),     32'd0);
        rst    = 1'b0;
        en     = 1'b1;
        en_cyc = cyc;
        base   = mon_frames;
        wait_frame(base, 400, "post-abort frame");
        check("post-abort start", 32'(fall_cyc - en_cyc), 32'd128);
        check("post-abort bits",  32'(last_bits),  32'h307FFF);
        check("post-abort edges", 32'(last_edges), 32'd24);
        en = 1'b0;
        check("mosi only changes on sclk fall", 32'(glitches), 32'd0);

        // SAMPLE_PERIOD=64: ten ticks, every second one dropped.
        en64 = 1'b1;
        step(670);
        en64 = 1'b0;
        step(150);
        check("p64 overruns",        32'(ovr64),     32'd5);
        check("p64 frames",          32'(f64_falls), 32'd5);
        check("p64 complete frames", 32'(f64_good),  32'd5);

        // Tick on the last HOLD cycle is dropped; one cycle later it is taken.
        enb = 1'b1;
        step(250);
        enb = 1'b0;
        step(150);
        check("p100 overrun on last hold", 32'(ovr100),     32'd1);
        check("p100 frames",               32'(f100_falls), 32'd1);
        check("p101 overruns",             32'(ovr101),     32'd0);
        check("p101 frames",               32'(f101_falls), 32'd2);
        check("aux instances idle",
              32'({busy64, busy100, busy101, strobe64, strobe100, strobe101}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
